// File: rtl/md5_iter_core.sv
// Iterative MD5 compression engine: ROUNDS_PER_CYCLE unrolled rounds per clock,
// then a one-cycle chaining add, with multi-block chaining and a target compare.
module md5_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit OUT_BYTE_SWAP    = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         chain,
  input  logic [511:0] mesg,
  input  logic [127:0] target,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] digest,
  output logic         match,
  output logic         busy
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16 || R == 32 || R == 64)) begin : g_bad_rounds
    $fatal(1, "md5_iter_core: ROUNDS_PER_CYCLE must be one of 1,2,4,8,16,32,64");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] fmt128(input logic [127:0] x);
    if (OUT_BYTE_SWAP)
      return {bswap32(x[127:96]), bswap32(x[95:64]), bswap32(x[63:32]), bswap32(x[31:0])};
    return x;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [4:0] md5_s(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'h0: return 5'd7;   4'h1: return 5'd12;  4'h2: return 5'd17;  4'h3: return 5'd22;
      4'h4: return 5'd5;   4'h5: return 5'd9;   4'h6: return 5'd14;  4'h7: return 5'd20;
      4'h8: return 5'd4;   4'h9: return 5'd11;  4'ha: return 5'd16;  4'hb: return 5'd23;
      4'hc: return 5'd6;   4'hd: return 5'd10;  4'he: return 5'd15;  default: return 5'd21;
    endcase
  endfunction

  // Message word schedule; only i mod 16 matters for the modulo-16 index.
  function automatic logic [3:0] md5_g(input logic [5:0] i);
    logic [3:0] n;
    n = i[3:0];
    case (i[5:4])
      2'd0:    return n;
      2'd1:    return (n << 2) + n + 4'd1;
      2'd2:    return (n << 1) + n + 4'd5;
      default: return (n << 3) - n;
    endcase
  endfunction

  function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [5:0] i,
                                            input logic [31:0] m);
    logic [31:0] a, b, c, d, f, t;
    {a, b, c, d} = st;
    case (i[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    t = a + f + K_TAB[i] + m;
    return {d, b + rotl32(t, md5_s(i)), b, c};
  endfunction

  state_t        r_state, w_next;
  logic [6:0]    r_rnd;
  logic [127:0]  r_st, r_init, r_chain, r_target, r_digest;
  logic [31:0]   r_m [16];
  logic          r_match, r_out_valid;

  logic          w_accept;
  logic [6:0]    w_rnd_next;
  logic [127:0]  w_init, w_sum, w_fmt;
  logic [127:0]  w_st [R+1];

  assign w_rnd_next = r_rnd + 7'(R);
  assign w_init     = chain ? r_chain : IV;
  assign w_accept   = in_ready && in_valid;
  assign w_sum      = {r_init[127:96] + r_st[127:96], r_init[95:64] + r_st[95:64],
                       r_init[63:32]  + r_st[63:32],  r_init[31:0]  + r_st[31:0]};
  assign w_fmt      = fmt128(w_sum);

  // Unrolled round chain: stage j applies round rnd+j.
  assign w_st[0] = r_st;
  for (genvar j = 0; j < R; j++) begin : g_round
    logic [5:0] w_idx;
    logic [3:0] w_gi;
    assign w_idx      = r_rnd[5:0] + 6'(j);
    assign w_gi       = md5_g(w_idx);
    assign w_st[j+1]  = md5_step(w_st[j], w_idx, r_m[w_gi]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !reset;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (en && (w_rnd_next == 7'd64)) w_next = S_FINAL;
      end
      S_FINAL: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Working state and latched block: no reset needed, always loaded on acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < 16; j++) r_m[j] <= bswap32(mesg[32*(15-j) +: 32]);
      r_target <= target;
      r_init   <= w_init;
      r_st     <= w_init;
    end else if (r_state == S_RUN && en) begin
      r_st <= w_st[R];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rnd       <= 7'd0;
      r_chain     <= IV;
      r_digest    <= '0;
      r_match     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_rnd <= 7'd0;
        S_RUN:   if (en) r_rnd <= w_rnd_next;
        S_FINAL: begin
          r_chain     <= w_sum;
          r_digest    <= w_fmt;
          r_match     <= (w_fmt == r_target);
          r_out_valid <= 1'b1;
        end
        S_DONE:  if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign digest    = r_digest;
  assign match     = r_match;

endmodule

// File: tb/tb_md5_iter_core.sv
// Scoreboard bench for md5_iter_core: several parameterisations driven with
// known MD5 vectors; a monitor pops expected digests as outputs appear.
module tb_md5_iter_core;

  localparam int NI = 6;
  localparam int RP  [NI] = '{1, 4, 2, 1, 8, 64};
  localparam bit SWP [NI] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  localparam logic [127:0] D_EMPTY   = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D_ABC     = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] D_ABC_RAW = 128'h98500190b04fd23c7d3f96d6727fe128;
  localparam logic [127:0] D_80      = 128'h57edf4a22be3c955ac49da2e2107b67a;
  localparam logic [511:0] M_EMPTY   = {8'h80, 504'h0};
  localparam logic [511:0] M_ABC     = {32'h61626380, 416'h0, 8'h18, 56'h0};
  localparam logic [511:0] M_B1      = "1234567890123456789012345678901234567890123456789012345678901234";
  localparam logic [511:0] M_B2      = {"5678901234567890", 8'h80, 312'h0, 8'h80, 8'h02, 48'h0};

  localparam int MD_EQ = 0, MD_NE = 1, MD_SKIP = 2;

  typedef struct {
    int           k;
    logic [127:0] dig;
    logic         m;
    int           mode;
    int           acc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic         en [NI], in_valid [NI], in_ready [NI], chain [NI];
  logic         out_valid [NI], out_ready [NI], match [NI], busy [NI];
  logic [511:0] mesg [NI];
  logic [127:0] target [NI], digest [NI];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];
  exp_t e;
  logic seen [NI] = '{default: 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    md5_iter_core #(.ROUNDS_PER_CYCLE(RP[k]), .OUT_BYTE_SWAP(SWP[k])) u_dut (
      .clk(clk), .reset(reset), .en(en[k]), .in_valid(in_valid[k]), .in_ready(in_ready[k]),
      .chain(chain[k]), .mesg(mesg[k]), .target(target[k]), .out_valid(out_valid[k]),
      .out_ready(out_ready[k]), .digest(digest[k]), .match(match[k]), .busy(busy[k])
    );
  end

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (out_valid[k] && !seen[k]) begin
        seen[k] <= 1'b1;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out[%0d]: out_valid with no expected entry", k);
        end else begin
          e = sb.pop_front();
          chkint($sformatf("sb_inst[%0d]", k), k, e.k);
          if (e.mode == MD_EQ)
            chk128($sformatf("digest[%0d]", k), digest[k], e.dig);
          else if (e.mode == MD_NE) begin
            n_cmp++;
            if (digest[k] === e.dig) begin
              n_bad++;
              $display("FAIL digest_differs[%0d]: got %h required different from %h", k, digest[k], e.dig);
            end
          end
          chk1($sformatf("match[%0d]", k), match[k], e.m);
          if (e.lat >= 0) chkint($sformatf("latency[%0d]", k), cyc - e.acc, e.lat);
        end
      end else if (!out_valid[k]) begin
        seen[k] <= 1'b0;
      end
    end
  end

  task automatic issue(input int k, input logic [511:0] m, input logic ch,
                       input logic [127:0] tg, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (!in_ready[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout[%0d]: in_ready stayed 0 expected 1", k);
      return;
    end
    mesg[k]     = m;
    chain[k]    = ch;
    target[k]   = tg;
    in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid[k] = 1'b0;
    mesg[k]     = '0;
    target[k]   = ~tg;
    chain[k]    = ~ch;
  endtask

  task automatic send(input int k, input logic [511:0] m, input logic ch, input logic [127:0] tg,
                      input logic [127:0] dig, input logic mm, input int mode, input int lat);
    int   acc;
    exp_t x;
    issue(k, m, ch, tg, acc);
    if (acc >= 0) begin
      x.k = k; x.dig = dig; x.m = mm; x.mode = mode; x.acc = acc; x.lat = lat;
      sb.push_back(x);
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid[k] || busy[k]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout[%0d]: %0d outputs still pending expected 0", k, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int acc;
    int n;
    for (int k = 0; k < NI; k++) begin
      en[k] = 1'b1; in_valid[k] = 1'b0; chain[k] = 1'b0; out_ready[k] = 1'b1;
      mesg[k] = '0; target[k] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("rst_in_ready[%0d]", k), in_ready[k], 1'b0);
      chk1($sformatf("rst_out_valid[%0d]", k), out_valid[k], 1'b0);
      chk128($sformatf("rst_digest[%0d]", k), digest[k], 128'h0);
      chk1($sformatf("rst_match[%0d]", k), match[k], 1'b0);
      chk1($sformatf("rst_busy[%0d]", k), busy[k], 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk1($sformatf("idle_in_ready[%0d]", k), in_ready[k], 1'b1);

    // MD5("") at R=1; chain=1 right after reset must start from the IV.
    send(0, M_EMPTY, 1'b1, D_EMPTY, D_EMPTY, 1'b1, MD_EQ, 65);
    wait_idle(0);
    send(0, M_EMPTY, 1'b0, 128'h0, D_EMPTY, 1'b0, MD_EQ, 65);
    wait_idle(0);

    // MD5("abc") at R=4 with a non-matching target.
    send(1, M_ABC, 1'b0, 128'h0, D_ABC, 1'b0, MD_EQ, 17);
    wait_idle(1);

    // Two-block message at R=2, then block 2 alone from the IV.
    send(2, M_B1, 1'b0, 128'h0, 128'h0, 1'b0, MD_SKIP, 33);
    wait_idle(2);
    send(2, M_B2, 1'b1, D_80, D_80, 1'b1, MD_EQ, 33);
    wait_idle(2);
    send(2, M_B2, 1'b0, D_80, D_80, 1'b0, MD_NE, 33);
    wait_idle(2);

    // Random en stalls and 10 cycles of output backpressure.
    out_ready[1] = 1'b0;
    send(1, M_ABC, 1'b0, D_ABC, D_ABC, 1'b1, MD_EQ, -1);
    n = 0;
    while (!out_valid[1] && n < 3000) begin
      @(negedge clk);
      en[1] = 1'($urandom_range(0, 1));
      n++;
    end
    en[1] = 1'b1;
    chk1("stall_out_valid_seen", out_valid[1], 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk1($sformatf("hold_out_valid[%0d]", i), out_valid[1], 1'b1);
      chk128($sformatf("hold_digest[%0d]", i), digest[1], D_ABC);
      chk1($sformatf("hold_in_ready[%0d]", i), in_ready[1], 1'b0);
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    chk1("take_in_ready_before", in_ready[1], 1'b0);
    @(negedge clk);
    chk1("take_out_valid_after", out_valid[1], 1'b0);
    chk1("take_in_ready_after", in_ready[1], 1'b1);
    wait_idle(1);

    // Reset in the middle of RUN at round 30.
    issue(0, M_EMPTY, 1'b0, D_EMPTY, acc);
    repeat (30) @(posedge clk);
    #1;
    chk1("midrun_busy", busy[0], 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk1("midrst_out_valid", out_valid[0], 1'b0);
    chk1("midrst_busy", busy[0], 1'b0);
    chk1("midrst_in_ready", in_ready[0], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk1("postrst_in_ready", in_ready[0], 1'b1);
    chk1("postrst_busy", busy[0], 1'b0);
    chk1("postrst_out_valid", out_valid[0], 1'b0);
    send(0, M_EMPTY, 1'b1, D_EMPTY, D_EMPTY, 1'b1, MD_EQ, 65);
    wait_idle(0);

    // Raw word output of "abc" across R = 1, 8, 64.
    send(3, M_ABC, 1'b0, D_ABC_RAW, D_ABC_RAW, 1'b1, MD_EQ, 65);
    wait_idle(3);
    send(4, M_ABC, 1'b0, D_ABC, D_ABC_RAW, 1'b0, MD_EQ, 9);
    wait_idle(4);
    send(5, M_ABC, 1'b0, D_ABC_RAW, D_ABC_RAW, 1'b1, MD_EQ, 2);
    wait_idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
